// File: rtl/ref_mb_loader.sv
// ref_mb_loader
//   Ping-pong loader for one 16x16 8-bit reference macroblock (MB) per bank.
//   The input stream delivers four pixels per beat in raster order, with
//   byte [7:0] first. A bank is marked full after 64 accepted beats.
//   The consumer reads pixels by index (row*16+col) with one cycle of read
//   latency, then releases the bank to hand it back to the writer.
//
//   Optional feature macro: MB_COUNT_EN. When it is defined, the module adds
//   the mb_count output, a wrapping count of completed MBs.
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   rst_n         : synchronous active-low reset (control state only)
//   s_valid       : input beat valid
//   s_ready       : loader accepts a beat this cycle (write bank not full)
//   s_data[31:0]  : four reference pixels, [7:0] first
//   rd_addr[7:0]  : pixel index in the read bank, registered internally
//   rd_data[7:0]  : pixel at the previous cycle's rd_addr
//   rd_bank_valid : read bank holds a complete MB
//   rd_release    : consumer is done with the read bank
//   wr_bank       : bank being filled
//   rd_bank       : bank being read
//   err_release   : sticky; set by a release while no bank is valid
//   mb_count[15:0]: completed MB count (only with MB_COUNT_EN)

module ref_mb_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_bank_valid,
    input  logic        rd_release,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        err_release
`ifdef MB_COUNT_EN
    ,
    output logic [15:0] mb_count
`endif
);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [5:0] beat_cnt;
    logic       accept;
    logic       last_beat;
    logic       release_ok;
    logic       release_bad;

    // Both banks in one array; the bank select is the top address bit.
    logic [7:0] mem [0:511];

    always_comb begin
        s_ready       = !full[wr_bank];
        rd_bank_valid = full[rd_bank];
        accept        = s_valid && s_ready;
        last_beat     = accept && (beat_cnt == 6'd63);
        release_ok    = rd_release && full[rd_bank];
        release_bad   = rd_release && !full[rd_bank];

        // A completion and a release always target different banks, because
        // a full bank is never written. So both updates can apply in the
        // same cycle without interfering.
        full_nxt = full;
        if (last_beat) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (release_ok) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full        <= '0;
            beat_cnt    <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            err_release <= 1'b0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                beat_cnt <= last_beat ? 6'd0 : beat_cnt + 6'd1;
            end
            if (last_beat) begin
                wr_bank <= ~wr_bank;
            end
            if (release_ok) begin
                rd_bank <= ~rd_bank;
            end
            if (release_bad) begin
                err_release <= 1'b1;
            end
        end
    end

    // Pixel storage has no reset; only the control state above is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[{wr_bank, beat_cnt, k[1:0]}] <= s_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

`ifdef MB_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mb_count <= '0;
        end else if (last_beat) begin
            mb_count <= mb_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ref_mb_loader.sv
// tb_ref_mb_loader
//   Directed bench for ref_mb_loader. Inputs are driven and outputs are
//   sampled on the falling edge of the clock. Expected pixel values come from
//   the same pattern functions that generate the stimulus. Build with
//   +define+MB_COUNT_EN to also check mb_count.

module tb_ref_mb_loader;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_bank_valid;
    logic        rd_release;
    logic        wr_bank;
    logic        rd_bank;
    logic        err_release;
`ifdef MB_COUNT_EN
    logic [15:0] mb_count;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    ref_mb_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_bank_valid(rd_bank_valid),
        .rd_release   (rd_release),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .err_release  (err_release)
`ifdef MB_COUNT_EN
        ,
        .mb_count     (mb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: pixel = address; mode 1: pixel = ~address; mode 2: 0xAA
    function automatic logic [7:0] exp_byte(input int mode, input int addr);
        logic [7:0] b;
        b = 8'(addr);
        if (mode == 1) b = ~b;
        if (mode == 2) b = 8'hAA;
        return b;
    endfunction

    function automatic logic [31:0] pat(input int mode, input int n);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            p[8*k +: 8] = exp_byte(mode, 4*n + k);
        end
        return p;
    endfunction

    task automatic put_beat(input logic [31:0] d, input bit gap, input bit rel);
        int unsigned w = 0;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) check("ready_timeout", {31'd0, s_ready}, 32'd1);
        s_valid    = 1'b1;
        s_data     = d;
        rd_release = rel;
        @(negedge clk);
        s_valid    = 1'b0;
        rd_release = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic load_beats(input int mode, input int first, input int count, input bit gap);
        for (int n = first; n < first + count; n++) begin
            put_beat(pat(mode, n), gap, 1'b0);
        end
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        @(negedge clk);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_release();
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        rd_addr    = '0;
        rd_release = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("rst_err", {31'd0, err_release}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_valid", {31'd0, rd_bank_valid}, 32'd0);

        // Bad release with no full bank
        pulse_release();
        check("bad_rel_err", {31'd0, err_release}, 32'd1);
        check("bad_rel_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("bad_rel_valid", {31'd0, rd_bank_valid}, 32'd0);
        check("bad_rel_s_ready", {31'd0, s_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("bad_rel_err_held", {31'd0, err_release}, 32'd1);
        do_reset();
        check("err_cleared", {31'd0, err_release}, 32'd0);

        // Single MB into bank 0
        load_beats(0, 0, 63, 1'b0);
        check("mb1_not_yet_valid", {31'd0, rd_bank_valid}, 32'd0);
        load_beats(0, 63, 1, 1'b0);
        check("mb1_valid", {31'd0, rd_bank_valid}, 32'd1);
        check("mb1_wr_bank", {31'd0, wr_bank}, 32'd1);
        check("mb1_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("mb1_s_ready", {31'd0, s_ready}, 32'd1);
        read_chk("mb1_rd_35", 8'h35, 8'h35);
        rd_addr = 8'h10;
        #1;
        check("mb1_latency", {24'd0, rd_data}, 32'h35);
        @(negedge clk);
        check("mb1_rd_10", {24'd0, rd_data}, 32'h10);
        read_chk("mb1_rd_00", 8'h00, 8'h00);
        read_chk("mb1_rd_ff", 8'hFF, 8'hFF);

        // Backpressure: second MB into bank 1, no release
        load_beats(1, 0, 64, 1'b0);
        check("bp_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("bp_rd_bank", {31'd0, rd_bank}, 32'd0);
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("bp_held", {31'd0, s_ready}, 32'd0);
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        s_valid    = 1'b0;
        check("bp_rel_rd_bank", {31'd0, rd_bank}, 32'd1);
        check("bp_rel_s_ready", {31'd0, s_ready}, 32'd1);
        check("bp_rel_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("bp_rel_valid", {31'd0, rd_bank_valid}, 32'd1);
        read_chk("bank1_rd_35", 8'h35, 8'hCA);
        read_chk("bank1_rd_00", 8'h00, 8'hFF);

        // Simultaneous completion of bank 1 and release of bank 0
        pulse_release();
        check("drain_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("drain_valid", {31'd0, rd_bank_valid}, 32'd0);
        load_beats(0, 0, 64, 1'b0);
        load_beats(1, 0, 63, 1'b0);
        put_beat(pat(1, 63), 1'b0, 1'b1);
        check("sim_rd_bank", {31'd0, rd_bank}, 32'd1);
        check("sim_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("sim_valid", {31'd0, rd_bank_valid}, 32'd1);
        check("sim_s_ready", {31'd0, s_ready}, 32'd1);
        check("sim_err", {31'd0, err_release}, 32'd0);
        read_chk("sim_rd_35", 8'h35, 8'hCA);
        read_chk("sim_rd_ff", 8'hFF, 8'h00);

        // Reset mid-load
        load_beats(1, 0, 30, 1'b0);
        do_reset();
        check("midrst_valid", {31'd0, rd_bank_valid}, 32'd0);
        check("midrst_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("midrst_rd_bank", {31'd0, rd_bank}, 32'd0);
        load_beats(2, 0, 63, 1'b0);
        check("midrst_not_yet_valid", {31'd0, rd_bank_valid}, 32'd0);
        load_beats(2, 63, 1, 1'b0);
        check("midrst_valid_done", {31'd0, rd_bank_valid}, 32'd1);
        check("midrst_wr_done", {31'd0, wr_bank}, 32'd1);
        for (int a = 0; a < 256; a++) begin
            read_chk("midrst_rd", 8'(a), 8'hAA);
        end

        // Gapped stream
        do_reset();
        load_beats(0, 0, 64, 1'b1);
        check("gap_valid", {31'd0, rd_bank_valid}, 32'd1);
        check("gap_wr_bank", {31'd0, wr_bank}, 32'd1);
        for (int a = 0; a < 256; a++) begin
            read_chk("gap_rd", 8'(a), 8'(a));
        end
`ifdef MB_COUNT_EN
        check("gap_mb_count", {16'd0, mb_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
